// File: rtl/pac_man_pkg.sv
// Shared types and constants for the Pac-Man input controller.
//   dir_t       : movement direction held in the pending and current registers
//   state_t     : move-sequencing FSM states
//   GRID_W      : blocks per maze row
//   START_BLOCK : block index where Pac-Man starts after reset
package pac_man_pkg;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } dir_t;

  typedef enum logic [2:0] {
    WAIT     = 3'd0,
    TRY_PEND = 3'd1,
    CHK_PEND = 3'd2,
    TRY_CUR  = 3'd3,
    CHK_CUR  = 3'd4
  } state_t;

  localparam int         GRID_W      = 32;
  localparam logic [9:0] START_BLOCK = 10'd495;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer followed by a rising-edge detector for one raw button.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   key   : raw asynchronous button, active high
//   rise  : one-cycle pulse when the synchronized key goes 0 -> 1
module key_sync (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic rise
);

  logic sync_meta;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      prev_q    <= 1'b0;
    end else begin
      sync_meta <= key;
      sync_q    <= sync_meta;
      prev_q    <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/pac_man_input_ctrl.sv
// Turns player buttons into one-cycle move requests, one attempt per movement
// tick. A newly pressed direction is buffered as pending and tried first; if
// the movement stage does not move (wall), the current direction is tried as
// a fallback so Pac-Man keeps going until the buffered turn becomes possible.
// Ports:
//   clk, reset                          : system clock, async active-low reset
//   key_up/down/left/right              : raw player buttons, active high
//   en                                  : game running, gates movement ticks
//   curr_block                          : Pac-Man block index from movement stage
//   up/down/left/right                  : one-cycle move requests (one-hot or 0)
//   tick                                : pulse for each accepted movement tick
//
// state    | meaning
// ---------+-------------------------------------------------------------
// WAIT     | idle until a movement tick arrives
// TRY_PEND | request the pending (buffered) direction, snapshot block
// CHK_PEND | moved -> pending becomes current; blocked -> try current
// TRY_CUR  | request the current direction, snapshot block
// CHK_CUR  | blocked -> stop (current cleared); always back to WAIT
module pac_man_input_ctrl
  import pac_man_pkg::*;
#(
  parameter int TICK_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       en,
  input  logic [9:0] curr_block,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       tick
);

  localparam int                CNT_W    = $clog2(TICK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] tick_cnt;
  logic             tick_int;

  logic   rise_up, rise_down, rise_left, rise_right;
  state_t state, state_nxt;
  dir_t   pending_dir, pending_nxt;
  dir_t   cur_dir, cur_nxt;
  dir_t   move_dir;
  logic [9:0] snap_block;

  key_sync u_sync_up    (.clk(clk), .reset(reset), .key(key_up),    .rise(rise_up));
  key_sync u_sync_down  (.clk(clk), .reset(reset), .key(key_down),  .rise(rise_down));
  key_sync u_sync_left  (.clk(clk), .reset(reset), .key(key_left),  .rise(rise_left));
  key_sync u_sync_right (.clk(clk), .reset(reset), .key(key_right), .rise(rise_right));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (tick_cnt == CNT_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_ONE;
    end
  end

  assign tick_int = (tick_cnt == CNT_LAST) && en;
  // Ticks landing mid-sequence are dropped rather than queued.
  assign tick     = tick_int && (state == WAIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= WAIT;
      pending_dir <= NONE;
      cur_dir     <= NONE;
      snap_block  <= '0;
    end else begin
      state       <= state_nxt;
      pending_dir <= pending_nxt;
      cur_dir     <= cur_nxt;
      if (state == TRY_PEND || state == TRY_CUR) begin
        snap_block <= curr_block;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending_dir;
    cur_nxt     = cur_dir;
    case (state)
      WAIT: begin
        if (tick_int) begin
          if (pending_dir != NONE)  state_nxt = TRY_PEND;
          else if (cur_dir != NONE) state_nxt = TRY_CUR;
        end
      end
      TRY_PEND: state_nxt = CHK_PEND;
      CHK_PEND: begin
        if (curr_block != snap_block) begin
          cur_nxt     = pending_dir;
          pending_nxt = NONE;
          state_nxt   = WAIT;
        end else if (cur_dir != NONE) begin
          state_nxt = TRY_CUR;
        end else begin
          state_nxt = WAIT;
        end
      end
      TRY_CUR: state_nxt = CHK_CUR;
      CHK_CUR: begin
        if (curr_block == snap_block) cur_nxt = NONE;
        state_nxt = WAIT;
      end
      default: state_nxt = WAIT;
    endcase
    // A fresh key edge overrides the pending clear of a successful turn.
    if (rise_up)         pending_nxt = UP;
    else if (rise_down)  pending_nxt = DOWN;
    else if (rise_left)  pending_nxt = LEFT;
    else if (rise_right) pending_nxt = RIGHT;
  end

  always_comb begin
    move_dir = NONE;
    if (state == TRY_PEND)     move_dir = pending_dir;
    else if (state == TRY_CUR) move_dir = cur_dir;
    up    = (move_dir == UP);
    down  = (move_dir == DOWN);
    left  = (move_dir == LEFT);
    right = (move_dir == RIGHT);
  end

endmodule

// File: tb/tb_pac_man_input_ctrl.sv
// Bench: DUT plus a movement-stage model on a 32x32 map. A tick-level planner
// predicts, at each movement tick, which move requests appear and where
// Pac-Man ends up; per-cycle outputs are compared against that plan.
module tb_pac_man_input_ctrl;
  import pac_man_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic       en = 1'b1;
  logic [9:0] curr_block;
  logic       up, down, left, right, tick;

  pac_man_input_ctrl #(.TICK_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .en(en), .curr_block(curr_block),
    .up(up), .down(down), .left(left), .right(right), .tick(tick)
  );

  always #5 clk = ~clk;

  bit walls [0:1023];

  function automatic int nb(input int cb, input dir_t d);
    int row, col;
    row = cb / GRID_W;
    col = cb % GRID_W;
    case (d)
      UP:      return (row > 0)  ? cb - GRID_W : -1;
      DOWN:    return (row < 31) ? cb + GRID_W : -1;
      LEFT:    return (col > 0)  ? cb - 1 : -1;
      RIGHT:   return (col < 31) ? cb + 1 : -1;
      default: return -1;
    endcase
  endfunction

  function automatic bit is_open(input int cb, input dir_t d);
    int n;
    n = nb(cb, d);
    if (n < 0) return 1'b0;
    return !walls[n];
  endfunction

  // Movement stage: moves one block on a request if the target is open.
  always @(posedge clk or negedge reset) begin
    if (!reset) curr_block <= START_BLOCK;
    else if (up    && is_open(int'(curr_block), UP))    curr_block <= 10'(nb(int'(curr_block), UP));
    else if (down  && is_open(int'(curr_block), DOWN))  curr_block <= 10'(nb(int'(curr_block), DOWN));
    else if (left  && is_open(int'(curr_block), LEFT))  curr_block <= 10'(nb(int'(curr_block), LEFT));
    else if (right && is_open(int'(curr_block), RIGHT)) curr_block <= 10'(nb(int'(curr_block), RIGHT));
  end

  int       n_pass = 0;
  int       n_total = 0;
  int       m = 0;
  dir_t     m_pend = NONE;
  dir_t     m_cur = NONE;
  int       m_cb = int'(START_BLOCK);
  dir_t     sched [4];
  bit [3:0] lvl = 4'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] dmask(input dir_t d);
    case (d)
      UP:      return 4'b1000;
      DOWN:    return 4'b0100;
      LEFT:    return 4'b0010;
      RIGHT:   return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic set_keys(input bit [3:0] v);
    key_up = v[3]; key_down = v[2]; key_left = v[1]; key_right = v[0];
  endtask

  task automatic model_keys(input bit [3:0] v);
    bit [3:0] rise;
    rise = v & ~lvl;
    if (rise[3])      m_pend = UP;
    else if (rise[2]) m_pend = DOWN;
    else if (rise[1]) m_pend = LEFT;
    else if (rise[0]) m_pend = RIGHT;
    lvl = v;
  endtask

  // One movement tick: try pending first, fall back to current two cycles later.
  task automatic plan();
    if (m_pend != NONE) begin
      sched[0] = m_pend;
      if (is_open(m_cb, m_pend)) begin
        m_cb = nb(m_cb, m_pend);
        m_cur = m_pend;
        m_pend = NONE;
      end else if (m_cur != NONE) begin
        sched[2] = m_cur;
        if (is_open(m_cb, m_cur)) m_cb = nb(m_cb, m_cur);
        else m_cur = NONE;
      end
    end else if (m_cur != NONE) begin
      sched[0] = m_cur;
      if (is_open(m_cb, m_cur)) m_cb = nb(m_cb, m_cur);
      else m_cur = NONE;
    end
  endtask

  task automatic cycle_body();
    chk("tick", 32'(tick), 32'(m == 7 && en));
    chk("moves", 32'({up, down, left, right}), 32'(dmask(sched[0])));
    if (m == 7) chk("curr_block", 32'(curr_block), 32'(m_cb));
    sched[0] = sched[1]; sched[1] = sched[2]; sched[2] = sched[3]; sched[3] = NONE;
    if (m == 7 && en) plan();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    m = (m + 1) % 8;
  endtask

  task automatic apply_reset();
    set_keys(4'b0);
    lvl = 4'b0;
    reset = 1'b0;
    #1;
    chk("rst_outs_now", 32'({up, down, left, right, tick}), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_outs_held", 32'({up, down, left, right, tick}), 32'd0);
    chk("rst_block", 32'(curr_block), 32'(START_BLOCK));
    m_pend = NONE; m_cur = NONE; m_cb = int'(START_BLOCK);
    for (int i = 0; i < 4; i++) sched[i] = NONE;
    reset = 1'b1;
    m = 0;
  endtask

  // Starts on an unchecked phase-0 cycle and leaves the next one unchecked.
  task automatic epoch(input bit [3:0] press, input bit [3:0] rel, input int act_ph,
                       input bit en_v, input bit do_rst);
    bit [3:0] v;
    en = en_v;
    for (int i = 0; i < 8; i++) begin
      cycle_body();
      if (m == act_ph) begin
        if (do_rst) begin
          apply_reset();
          return;
        end
        v = (lvl | press) & ~rel;
        set_keys(v);
        model_keys(v);
      end
      step();
    end
  endtask

  initial begin
    bit [3:0] pr, rl;
    for (int i = 0; i < 1024; i++) walls[i] = 1'b0;
    walls[465] = 1'b1; walls[466] = 1'b1; walls[467] = 1'b1;  // ceiling during first turn
    walls[471] = 1'b1;                                         // right-hand stop
    walls[374] = 1'b1;                                         // up-column stop
    walls[440] = 1'b1; walls[441] = 1'b1; walls[442] = 1'b1; walls[443] = 1'b1;
    walls[412] = 1'b1;
    walls[347] = 1'b1;
    for (int i = 0; i < 4; i++) sched[i] = NONE;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", 32'({up, down, left, right, tick}), 32'd0);
    chk("reset_block", 32'(curr_block), 32'(START_BLOCK));
    reset = 1'b1;
    m = 0;

    epoch(4'b0000, 4'b0000, 3, 1'b1, 1'b0);  // idle: nothing pending
    epoch(4'b0001, 4'b0000, 3, 1'b1, 1'b0);  // press right
    epoch(4'b0000, 4'b0001, 3, 1'b1, 1'b0);
    chk("first_move_block", 32'(curr_block), 32'd496);
    epoch(4'b1000, 4'b0000, 3, 1'b1, 1'b0);  // buffered up under a wall
    epoch(4'b0000, 4'b1000, 3, 1'b1, 1'b0);
    epoch(4'b0000, 4'b0000, 3, 1'b1, 1'b0);
    epoch(4'b0000, 4'b0000, 3, 1'b1, 1'b0);  // up opens: turn taken
    epoch(4'b0001, 4'b0000, 3, 1'b1, 1'b0);
    epoch(4'b0000, 4'b0001, 3, 1'b1, 1'b0);
    epoch(4'b0000, 4'b0000, 3, 1'b1, 1'b0);  // right into wall: stop
    epoch(4'b1010, 4'b0000, 3, 1'b1, 1'b0);  // up+left together: up wins
    epoch(4'b0000, 4'b1010, 3, 1'b1, 1'b0);
    epoch(4'b0000, 4'b0000, 3, 1'b1, 1'b0);
    epoch(4'b0001, 4'b0000, 3, 1'b1, 1'b0);
    epoch(4'b0000, 4'b0001, 3, 1'b1, 1'b0);
    epoch(4'b0100, 4'b0000, 3, 1'b1, 1'b0);  // hold down 40 cycles against wall
    repeat (4) epoch(4'b0000, 4'b0000, 3, 1'b1, 1'b0);
    epoch(4'b0000, 4'b0100, 3, 1'b1, 1'b0);
    epoch(4'b0000, 4'b0000, 3, 1'b0, 1'b0);  // en low: no tick
    epoch(4'b0010, 4'b0000, 3, 1'b1, 1'b0);
    epoch(4'b0000, 4'b0010, 3, 1'b1, 1'b0);
    epoch(4'b1000, 4'b0000, 3, 1'b0, 1'b0);
    epoch(4'b0001, 4'b0000, 7, 1'b1, 1'b0);  // edge lands on the pending clear
    epoch(4'b0000, 4'b1001, 3, 1'b1, 1'b0);
    epoch(4'b0000, 4'b0000, 3, 1'b1, 1'b0);
    epoch(4'b1000, 4'b0000, 3, 1'b1, 1'b0);  // blocked pending + fallback
    epoch(4'b0000, 4'b0000, 3, 1'b1, 1'b1);  // reset during CHK_CUR
    epoch(4'b0000, 4'b0000, 3, 1'b1, 1'b0);
    epoch(4'b0000, 4'b0000, 3, 1'b1, 1'b0);

    for (int e = 0; e < 150; e++) begin
      pr = ($urandom_range(0, 2) == 0) ? (4'($urandom) & ~lvl) : 4'b0000;
      rl = 4'($urandom) & lvl;
      epoch(pr, rl, ($urandom_range(0, 1) == 0) ? 3 : 7,
            ($urandom_range(0, 3) != 0), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
